// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider
//
// Multi-cycle restoring divider. An unsigned DIVIDEND_WIDTH-bit dividend is
// divided by an unsigned DIVISOR_WIDTH-bit divisor, resolving one quotient bit
// per clock. The default widths match the combinational multiplier, so that
// block's product can be fed back here and checked.
//
// Ports:
//   clock          in   system clock, all state on the rising edge
//   reset          in   synchronous active-high reset
//   start          in   request; sampled only while idle
//   dividend       in   [DIVIDEND_WIDTH-1:0] latched on an accepted start
//   divisor        in   [DIVISOR_WIDTH-1:0]  latched on an accepted start
//   busy           out  high while the divide loop is running
//   done           out  one-cycle pulse, results valid
//   quotient       out  [DIVIDEND_WIDTH-1:0] final quotient (all ones on /0)
//   remainder      out  [DIVISOR_WIDTH-1:0]  final remainder (0 on /0)
//   divide_by_zero out  set when the latched divisor was zero
//
// All outputs are registered. quotient/remainder only change on entry to
// DONE (or on reset), so intermediate values are never visible.
// ---------------------------------------------------------------------------
module sequential_divider #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      divide_by_zero
);

    // Bit counter wide enough to address every dividend bit.
    localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DIVIDEND_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;

    logic [DIVIDEND_WIDTH-1:0]   dividend_r;
    logic [DIVISOR_WIDTH-1:0]    divisor_r;
    logic [CW-1:0]               count_r;
    // Partial remainder is always < divisor between steps, so DIVISOR_WIDTH
    // bits hold it; the shifted value below carries the extra bit.
    logic [DIVISOR_WIDTH-1:0]    prem_r;
    logic [DIVIDEND_WIDTH-1:0]   quot_work_r;

    logic                        divisor_zero_s;
    logic [DIVISOR_WIDTH:0]      shifted_s;
    logic                        ge_s;
    logic [DIVISOR_WIDTH-1:0]    diff_s;
    logic [DIVISOR_WIDTH-1:0]    rem_next_s;
    logic [DIVIDEND_WIDTH-1:0]   quot_next_s;
    logic                        busy_next_s;
    logic                        done_next_s;

    assign divisor_zero_s = (divisor == {DIVISOR_WIDTH{1'b0}});

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = divisor_zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == {CW{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: busy/done follow the state being entered so that the
    // registered copies line up with the state register.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_RUN:  busy_next_s = 1'b1;
            ST_DONE: done_next_s = 1'b1;
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // One restoring step. The difference is taken modulo 2^DIVISOR_WIDTH:
    // it is only used when shifted >= divisor, where the true result fits.
    always_comb begin
        shifted_s   = {prem_r, dividend_r[count_r]};
        ge_s        = (shifted_s >= {1'b0, divisor_r});
        diff_s      = shifted_s[DIVISOR_WIDTH-1:0] - divisor_r;
        if (ge_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = shifted_s[DIVISOR_WIDTH-1:0];
        end
        // Bits are resolved MSB first, so shifting left places bit [count].
        quot_next_s = {quot_work_r[DIVIDEND_WIDTH-2:0], ge_s};
    end

    // Registered busy/done outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next_s;
            done <= done_next_s;
        end
    end

    // Datapath: operand latch, iteration registers and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            dividend_r     <= {DIVIDEND_WIDTH{1'b0}};
            divisor_r      <= {DIVISOR_WIDTH{1'b0}};
            count_r        <= {CW{1'b0}};
            prem_r         <= {DIVISOR_WIDTH{1'b0}};
            quot_work_r    <= {DIVIDEND_WIDTH{1'b0}};
            quotient       <= {DIVIDEND_WIDTH{1'b0}};
            remainder      <= {DIVISOR_WIDTH{1'b0}};
            divide_by_zero <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dividend_r     <= dividend;
                        divisor_r      <= divisor;
                        count_r        <= COUNT_LAST;
                        prem_r         <= {DIVISOR_WIDTH{1'b0}};
                        quot_work_r    <= {DIVIDEND_WIDTH{1'b0}};
                        divide_by_zero <= divisor_zero_s;
                        // Zero divisor skips the loop and publishes at once.
                        if (divisor_zero_s) begin
                            quotient  <= {DIVIDEND_WIDTH{1'b1}};
                            remainder <= {DIVISOR_WIDTH{1'b0}};
                        end
                    end
                end
                ST_RUN: begin
                    prem_r      <= rem_next_s;
                    quot_work_r <= quot_next_s;
                    count_r     <= count_r - {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == {CW{1'b0}}) begin
                        quotient  <= quot_next_s;
                        remainder <= rem_next_s;
                    end
                end
                default: begin
                    dividend_r <= dividend_r;
                end
            endcase
        end
    end

endmodule
